// File: rtl/mem_access_unit_if.sv
// Core-side request/response handshake and word-wide memory port
// for the load/store unit.
interface mem_access_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic [2:0]  req_funct3;
  logic        req_we;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;
  logic [31:0] mem_addr;
  logic [31:0] mem_wd;
  logic        mem_we;
  logic [31:0] mem_rd;

  modport slave (
    input  req_valid, req_funct3, req_we,
    input  req_addr, req_wdata, rsp_ready,
    input  mem_rd,
    output req_ready, rsp_valid, rsp_rdata,
    output rsp_err, mem_addr, mem_wd, mem_we
  );

  modport master (
    output req_valid, req_funct3, req_we,
    output req_addr, req_wdata, rsp_ready,
    output mem_rd,
    input  req_ready, rsp_valid, rsp_rdata,
    input  rsp_err, mem_addr, mem_wd, mem_we
  );
endinterface

// File: rtl/mem_access_unit.sv
// Load/store initiator on a word-only memory port: sub-word
// loads extract and extend, sub-word stores read-modify-write.
module mem_access_unit #(
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  mem_access_unit_if.slave bus
);
  typedef enum logic [1:0] {
    IDLE, ACCESS, WRITE, RESP
  } state_t;

  state_t      state;
  logic [2:0]  f3;
  logic        we;
  logic [31:0] addr;
  logic [31:0] wbuf;
  logic [31:0] rdata;
  logic        err;

  logic        illegal;
  logic        misal;
  logic        bad;
  logic [7:0]  lane_b;
  logic [15:0] lane_h;
  logic [31:0] lext;
  logic [31:0] merged;
  logic [31:0] word;

  always_comb begin
    illegal = 1'b0;
    unique case (bus.req_funct3)
      3'b011, 3'b110, 3'b111: illegal = 1'b1;
      3'b100, 3'b101:         illegal = bus.req_we;
      default:                illegal = 1'b0;
    endcase
  end

  always_comb begin
    misal = 1'b0;
    if (CHECK_ALIGN) begin
      unique case (bus.req_funct3[1:0])
        2'b01:   misal = bus.req_addr[0];
        2'b10:   misal = |bus.req_addr[1:0];
        default: misal = 1'b0;
      endcase
    end
  end

  assign bad    = illegal | misal;
  assign lane_b = bus.mem_rd[{addr[1:0], 3'b000} +: 8];
  assign lane_h = addr[1] ? bus.mem_rd[31:16]
                          : bus.mem_rd[15:0];

  always_comb begin
    lext = bus.mem_rd;
    unique case (f3[1:0])
      2'b00: lext = f3[2] ? {24'h0, lane_b}
                          : {{24{lane_b[7]}}, lane_b};
      2'b01: lext = f3[2] ? {16'h0, lane_h}
                          : {{16{lane_h[15]}}, lane_h};
      default: lext = bus.mem_rd;
    endcase
  end

  // Old word with only the addressed lane replaced by store data.
  always_comb begin
    merged = bus.mem_rd;
    if (f3[1:0] == 2'b00) begin
      unique case (addr[1:0])
        2'b00: merged[7:0]   = wbuf[7:0];
        2'b01: merged[15:8]  = wbuf[7:0];
        2'b10: merged[23:16] = wbuf[7:0];
        2'b11: merged[31:24] = wbuf[7:0];
      endcase
    end else if (addr[1]) begin
      merged[31:16] = wbuf[15:0];
    end else begin
      merged[15:0] = wbuf[15:0];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      f3    <= 3'b000;
      we    <= 1'b0;
      addr  <= 32'h0;
      wbuf  <= 32'h0;
      rdata <= 32'h0;
      err   <= 1'b0;
    end else begin
      unique case (state)
        IDLE: if (bus.req_valid) begin
          f3    <= bus.req_funct3;
          we    <= bus.req_we;
          addr  <= bus.req_addr;
          wbuf  <= bus.req_wdata;
          rdata <= 32'h0;
          err   <= bad;
          if (bad)
            state <= RESP;
          else if (bus.req_we &&
                   bus.req_funct3[1:0] == 2'b10)
            state <= WRITE;
          else
            state <= ACCESS;
        end
        ACCESS: begin
          if (we) begin
            wbuf  <= merged;
            state <= WRITE;
          end else begin
            rdata <= lext;
            state <= RESP;
          end
        end
        WRITE: state <= RESP;
        RESP: if (bus.rsp_ready) state <= IDLE;
      endcase
    end
  end

  assign word          = {addr[31:2], 2'b00};
  assign bus.req_ready = (state == IDLE);
  assign bus.rsp_valid = (state == RESP);
  assign bus.rsp_rdata = rdata;
  assign bus.rsp_err   = err;
  assign bus.mem_addr  = (state == ACCESS || state == WRITE)
                         ? word : 32'h0;
  assign bus.mem_wd    = (state == WRITE) ? wbuf : 32'h0;
  assign bus.mem_we    = (state == WRITE);
endmodule

// File: doc/mem_access_unit.md
Name: mem_access_unit

Overview:
- Initiator side of the unified instruction/data memory port. Takes load/store requests from the multicycle core.
- Drives the word-wide memory port: memory address, write data, memory write enable, and combinational read data returned the same cycle.
- The memory writes whole words only, so LB/LH/LBU/LHU are performed as word read + lane extract + extension, and SB/SH as read-modify-write.
- Returns load data, with a response handshake and an error flag for misaligned or illegal requests.

Parameters:
CHECK_ALIGN, 1, 1: misaligned LH/LHU/SH/LW/SW are rejected with rsp_err; 0: address low bits below the access size are ignored (address forced to natural alignment).

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  asynchronous active-low reset
req_valid  input  1  request present
req_ready  output  1  unit can accept a request
req_funct3  input  3  RV32I funct3 (000 B, 001 H, 010 W, 100 BU, 101 HU)
req_we  input  1  1 = store, 0 = load
req_addr  input  32  byte address
req_wdata  input  32  store data (low bits used for SB/SH)
rsp_valid  output  1  response present
rsp_ready  input  1  core accepts response
rsp_rdata  output  32  extended load data; 0 for stores and errors
rsp_err  output  1  misaligned or illegal funct3
mem_addr  output  32  word address to memory, bits [1:0] always 0
mem_wd  output  32  write data to memory
mem_we  output  1  memory write enable
mem_rd  input  32  combinational read data for mem_addr

Behaviour:
- Clock and reset: one clock, clk; reset asynchronous active-low, rst_n.
- Reset: state IDLE. req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, mem_we=0, mem_addr=0, mem_wd=0.
- Output decode: req_ready = (state==IDLE). Memory outputs decode from state and latched registers; all are 0 in IDLE and RESP.
- States: IDLE, ACCESS, WRITE, RESP.
- IDLE, on req_valid:
  - latch funct3, we, addr, wdata;
  - classify the request:
    - illegal: funct3 011/110/111, or store with funct3 100/101;
    - misaligned (CHECK_ALIGN=1): H-type with addr[0]=1, or W-type with addr[1:0]!=0;
  - next state: illegal or misaligned -> RESP with err=1 (no memory access); load -> ACCESS; SW -> WRITE; SB/SH -> ACCESS.
- ACCESS:
  - mem_addr={addr[31:2],2'b00}, mem_we=0; mem_rd captured at the clock edge.
  - Load: extract lane and extend (LB/LH sign-extend, LBU/LHU zero-extend, LW whole word), then -> RESP.
  - SB/SH: store merged word, then -> WRITE.
- Merge rules:
  - SB: lane addr[1:0] replaced with wdata[7:0].
  - SH: halfword addr[1] replaced with wdata[15:0].
  - Other bytes keep their old value.
- WRITE:
  - mem_addr = word address; mem_wd = merged word (SW: wdata); mem_we=1 for exactly this one cycle.
  - Next state: RESP.
- RESP: rsp_valid=1. rsp_rdata and rsp_err are held stable until rsp_ready. The cycle after rsp_valid&&rsp_ready -> IDLE.
- Latency, accept edge to rsp_valid high:
  - error: 1 cycle;
  - load or SW: 2 cycles;
  - SB/SH: 3 cycles.
- Throughput: one request in flight. A new request is accepted in the first IDLE cycle after the response handshake.
- req_* inputs are ignored outside IDLE. Latched copies are used, so the core may change inputs after acceptance.
- Address wrap beyond memory size is the memory's concern; the full address is passed through unchanged.
- Async reset mid-operation:
  - immediate return to IDLE; mem_we drops combinationally, so there is no write at the next edge;
  - the pending request is discarded and no response is issued.
- rsp_ready may be high before rsp_valid. There is no combinational path from rsp_ready to any mem_* output.

Test Plan:
- Word at 0x8 = 0x80FF7F01; issue LB 0x9, LB 0xA, LBU 0xB, LH 0xA, LHU 0xA, LW 0x8 -> rdata 0x0000007F, 0xFFFFFFFF, 0x00000080, 0xFFFF80FF, 0x000080FF, 0x80FF7F01; rsp_valid 2 cycles after each accept; mem_we never high.
- SB 0xA with wdata 0x123456AB onto 0x80FF7F01 -> one ACCESS cycle with mem_we=0, then one cycle mem_we=1 with mem_wd=0x80AB7F01; rsp_valid 3 cycles after accept, rsp_rdata=0.
- SH 0x6 with wdata 0xDEADBEEF onto word 0x4 = 0x11223344 -> word becomes 0xBEEF3344; SW 0x4 with 0xCAFEF00D -> mem_we in the cycle after accept, word 0xCAFEF00D, rsp_valid 2 cycles after accept.
- LW 0x6, SH 0x5, LB with funct3=011 -> rsp_err=1 after 1 cycle, mem_we never asserted, memory unchanged. With CHECK_ALIGN=0, LW 0x6 -> reads word 0x4, rsp_err=0.
- Hold rsp_ready low 5 cycles -> rsp_valid, rsp_rdata, rsp_err stable and req_ready=0; then back-to-back LW/SB both complete correctly.
- Assert rst_n low during WRITE -> mem_we low immediately, memory unchanged at the next edge, no rsp_valid; after release req_ready=1.
